register_file: RTL and testbench
================================

# register_file

Per-thread register file for one SIMT lane of the compute core: sixteen 8-bit registers, two read ports (rs, rt) and one write-back port. It sits directly upstream of the per-thread ALU. It captures rs/rt during the REQUEST core state so the ALU can consume them in EXECUTE. It writes back the ALU result, LSU load data or a decoded immediate during UPDATE. Registers r13–r15 are read-only thread-identity registers: block id, block dimension and thread id.

## Interface
- THREADS_PER_BLOCK, 4: value held in r14 (block dimension).
- THREAD_ID, 0: value held in r15 for this lane.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears state immediately.
- enable  in  1  lane active for the current block; 0 freezes all state.
- core_state  in  3  core pipeline state; 3'b011 = REQUEST, 3'b110 = UPDATE; other values are ignored here.
- block_id  in  8  id of the block currently running.
- decoded_rs_address  in  4  source register index for rs.
- decoded_rt_address  in  4  source register index for rt.
- decoded_rd_address  in  4  destination register index.
- decoded_reg_write_enable  in  1  instruction writes rd.
- decoded_reg_input_mux  in  2  write-back source: 00 alu_out, 01 lsu_out, 10 decoded_immediate, 11 reserved.
- decoded_immediate  in  8  immediate constant.
- alu_out  in  8  ALU result.
- lsu_out  in  8  load data from the LSU.
- rs  out  8  registered rs operand to the ALU/LSU.
- rt  out  8  registered rt operand to the ALU/LSU.
- illegal_write  out  1  sticky flag: a rejected write was attempted.

## Operation
- Storage: regs[0..15], 8 bits each. r0–r12 are general purpose. r13 = block_id, r14 = THREADS_PER_BLOCK[7:0], r15 = THREAD_ID[7:0].
- Reset (reset == 0, asynchronous):
  - r0–r12 = 0; r13 = 0; r14 = THREADS_PER_BLOCK; r15 = THREAD_ID.
  - rs = 0, rt = 0, illegal_write = 0.
  - Reset asserted mid-instruction aborts any pending read or write; nothing is written.
- enable == 0: no register, output or flag changes on any edge.
- Every enabled edge: r13 <= block_id. This happens in every core_state, so r13 tracks block_id with one cycle of lag.
- REQUEST (enable, core_state == 3'b011):
  - rs <= regs[decoded_rs_address]; rt <= regs[decoded_rt_address].
  - The read sees register contents from before the edge. r13 reads the previously latched block_id.
- UPDATE (enable, core_state == 3'b110, decoded_reg_write_enable == 1):
  - If rd < 13 and mux != 11: regs[rd] <= selected source (alu_out, lsu_out or decoded_immediate), truncated/passed as 8 bits; no extension.
  - If rd >= 13 or mux == 11: no register changes and illegal_write <= 1.
- UPDATE with decoded_reg_write_enable == 0: no write, flag unchanged.
- rs and rt hold their values in every state other than REQUEST.
- illegal_write clears only on reset.
- Writes to r0 are legal; r0 is not hardwired to zero.

## Timing
- Read latency: rs/rt are valid one cycle after the REQUEST edge. They remain stable through WAIT and EXECUTE, where the ALU samples them.
- Write latency: data is stored on the UPDATE edge. It is visible to the next instruction's REQUEST; there is no same-cycle bypass, because REQUEST and UPDATE never coincide.
- Write-back sources (alu_out, lsu_out, decoded_immediate) are sampled on the UPDATE edge only.
- All outputs are registered; there is no combinational path from inputs to rs, rt or illegal_write.

## Test plan
- Reset release, THREAD_ID = 2, THREADS_PER_BLOCK = 4, block_id = 5:
  - First REQUEST reading rs = 15, rt = 14 gives rs = 2, rt = 4.
  - A later REQUEST reading rs = 13 gives rs = 5.
- Immediate write then read:
  - UPDATE with rd = 3, mux = 10, imm = 8'hA5, then REQUEST rs = 3, rt = 0 -> rs = 8'hA5, rt = 0.
  - rs holds 8'hA5 through states 100/101.
- ALU and LSU write-back:
  - UPDATE rd = 1 from alu_out = 8'h7F, then UPDATE rd = 2 from lsu_out = 8'h80.
  - REQUEST rs = 1, rt = 2 -> rs = 8'h7F, rt = 8'h80.
- Protected write:
  - UPDATE rd = 14, mux = 00, alu_out = 8'h33 -> r14 stays 4 and illegal_write = 1.
  - illegal_write stays 1 across later legal instructions.
  - mux = 11 with rd = 4 -> r4 unchanged and illegal_write = 1.
- enable = 0: drive REQUEST and UPDATE (rd = 5, imm = 8'h11) and change block_id -> rs, rt, r5, r13 and illegal_write all unchanged.
- Asynchronous reset mid-instruction:
  - With r6 = 8'h42 and rs = 8'h42, pull reset low between clock edges -> rs, rt and illegal_write go to 0 immediately, without a clock edge.
  - After release, REQUEST rs = 6 -> rs = 0.

Source files
------------

// File: rtl/register_file.sv
// register_file: per-lane 16x8 register file with registered rs/rt reads and guarded write-back.
// r13..r15 hold block id, block dimension and thread id; writes to them are flagged as illegal.
module register_file #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] core_state,
  input  logic [7:0] block_id,
  input  logic [3:0] decoded_rs_address,
  input  logic [3:0] decoded_rt_address,
  input  logic [3:0] decoded_rd_address,
  input  logic       decoded_reg_write_enable,
  input  logic [1:0] decoded_reg_input_mux,
  input  logic [7:0] decoded_immediate,
  input  logic [7:0] alu_out,
  input  logic [7:0] lsu_out,
  output logic [7:0] rs,
  output logic [7:0] rt,
  output logic       illegal_write
);
  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] UPDATE = 3'b110;
  localparam logic [7:0] TPB = 8'(THREADS_PER_BLOCK);
  localparam logic [7:0] TID = 8'(THREAD_ID);
  logic [7:0] r_regs [16];
  logic [7:0] w_wdata;
  logic       w_legal;
  logic       w_write;
  always_comb begin
    w_wdata = decoded_reg_input_mux == 2'b00 ? alu_out :
              decoded_reg_input_mux == 2'b01 ? lsu_out : decoded_immediate;
    w_legal = decoded_rd_address < 4'd13 && decoded_reg_input_mux != 2'b11;
    w_write = core_state == UPDATE && decoded_reg_write_enable;
  end
  // r14/r15 are only ever loaded here, so they behave as read-only constants
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++)
        r_regs[i] <= i == 14 ? TPB : i == 15 ? TID : 8'h00;
      rs <= 8'h00;
      rt <= 8'h00;
      illegal_write <= 1'b0;
    end else if (enable) begin
      if (core_state == REQUEST) begin
        rs <= r_regs[decoded_rs_address];
        rt <= r_regs[decoded_rt_address];
      end
      if (w_write && w_legal)
        r_regs[decoded_rd_address] <= w_wdata;
      if (w_write && !w_legal)
        illegal_write <= 1'b1;
      r_regs[13] <= block_id;
    end
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vectors checked against a behavioural model every cycle plus literal expectations.
module tb_register_file;
  localparam int TPB = 4;
  localparam int TID = 2;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [2:0] core_state = 3'b000;
  logic [7:0] block_id = 8'd5;
  logic [3:0] rs_a = 4'd0, rt_a = 4'd0, rd_a = 4'd0;
  logic       we = 1'b0;
  logic [1:0] mx = 2'b00;
  logic [7:0] imm = 8'h00, alu = 8'h00, lsu = 8'h00;
  logic [7:0] rs, rt;
  logic       illegal_write;
  int n_pass = 0;
  int n_tot = 0;
  logic [7:0] m_gpr [13];
  logic [7:0] m_blk, m_rs, m_rt;
  logic       m_ill;
  register_file #(.THREADS_PER_BLOCK(TPB), .THREAD_ID(TID)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .block_id(block_id), .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
    .decoded_rd_address(rd_a), .decoded_reg_write_enable(we),
    .decoded_reg_input_mux(mx), .decoded_immediate(imm), .alu_out(alu),
    .lsu_out(lsu), .rs(rs), .rt(rt), .illegal_write(illegal_write)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] m_read(input logic [3:0] a);
    return a == 4'd15 ? 8'(TID) : a == 4'd14 ? 8'(TPB) : a == 4'd13 ? m_blk : m_gpr[a];
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 13; i++) m_gpr[i] = 8'h00;
      m_blk = 8'h00;
      m_rs = 8'h00;
      m_rt = 8'h00;
      m_ill = 1'b0;
    end else if (enable) begin
      if (core_state == 3'b011) begin
        m_rs = m_read(rs_a);
        m_rt = m_read(rt_a);
      end
      if (core_state == 3'b110 && we) begin
        if (rd_a >= 4'd13 || mx == 2'b11) m_ill = 1'b1;
        else m_gpr[rd_a] = mx == 2'b00 ? alu : mx == 2'b01 ? lsu : imm;
      end
      m_blk = block_id;
    end
  end
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    chk("model_rs", rs, m_rs);
    chk("model_rt", rt, m_rt);
    chk("model_ill", {7'd0, illegal_write}, {7'd0, m_ill});
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [3:0] a, input logic [3:0] b);
    core_state = 3'b011; rs_a = a; rt_a = b; we = 1'b0;
    cyc();
  endtask
  task automatic upd(input logic [3:0] d, input logic [1:0] m, input logic [7:0] v, input logic w);
    core_state = 3'b110; rd_a = d; mx = m; we = w;
    imm = v; alu = v; lsu = v;
    if (m != 2'b10) imm = ~v;
    if (m != 2'b00) alu = ~v;
    if (m != 2'b01) lsu = ~v;
    cyc();
  endtask
  task automatic idle(input logic [2:0] st);
    core_state = st; we = 1'b0;
    cyc();
  endtask
  initial begin
    cyc();
    chk("reset_rs", rs, 8'h00);
    chk("reset_rt", rt, 8'h00);
    chk("reset_ill", {7'd0, illegal_write}, 8'h00);
    reset = 1'b1;
    idle(3'b000);
    req(4'd15, 4'd14);
    chk("tid", rs, 8'd2);
    chk("tpb", rt, 8'd4);
    req(4'd13, 4'd0);
    chk("blk", rs, 8'd5);
    upd(4'd3, 2'b10, 8'hA5, 1'b1);
    req(4'd3, 4'd0);
    chk("imm_rs", rs, 8'hA5);
    chk("imm_rt", rt, 8'h00);
    idle(3'b100);
    chk("hold_wait", rs, 8'hA5);
    idle(3'b101);
    chk("hold_exec", rs, 8'hA5);
    upd(4'd1, 2'b00, 8'h7F, 1'b1);
    upd(4'd2, 2'b01, 8'h80, 1'b1);
    req(4'd1, 4'd2);
    chk("alu_wb", rs, 8'h7F);
    chk("lsu_wb", rt, 8'h80);
    upd(4'd14, 2'b00, 8'h33, 1'b1);
    chk("ill_r14", {7'd0, illegal_write}, 8'h01);
    req(4'd14, 4'd0);
    chk("r14_kept", rs, 8'd4);
    upd(4'd4, 2'b10, 8'h5A, 1'b1);
    upd(4'd4, 2'b11, 8'hC3, 1'b1);
    upd(4'd7, 2'b10, 8'h99, 1'b0);
    req(4'd4, 4'd7);
    chk("mux11_r4", rs, 8'h5A);
    chk("we0_r7", rt, 8'h00);
    chk("ill_sticky", {7'd0, illegal_write}, 8'h01);
    enable = 1'b0;
    block_id = 8'd9;
    req(4'd5, 4'd13);
    upd(4'd5, 2'b10, 8'h11, 1'b1);
    upd(4'd13, 2'b10, 8'h22, 1'b1);
    chk("dis_rs", rs, 8'h5A);
    chk("dis_rt", rt, 8'h00);
    enable = 1'b1;
    req(4'd5, 4'd13);
    chk("dis_r5", rs, 8'h00);
    chk("dis_r13", rt, 8'd5);
    req(4'd13, 4'd13);
    chk("blk_new", rs, 8'd9);
    upd(4'd6, 2'b10, 8'h42, 1'b1);
    req(4'd6, 4'd15);
    chk("r6", rs, 8'h42);
    idle(3'b100);
    #2 reset = 1'b0;
    #1;
    chk("async_rs", rs, 8'h00);
    chk("async_rt", rt, 8'h00);
    chk("async_ill", {7'd0, illegal_write}, 8'h00);
    cyc();
    reset = 1'b1;
    req(4'd6, 4'd14);
    chk("post_r6", rs, 8'h00);
    chk("post_tpb", rt, 8'd4);
    upd(4'd4, 2'b11, 8'h10, 1'b1);
    chk("ill_mux11", {7'd0, illegal_write}, 8'h01);
    req(4'd4, 4'd13);
    chk("post_r4", rs, 8'h00);
    chk("post_blk", rt, 8'd9);
    idle(3'b000);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
